// File: rtl/man_align_pipe.sv
// man_align_pipe: pipelined right-shift aligner producing {kept mantissa, G, R, S} with valid/ready flow.
// Define MAN_ALIGN_FLUSH_FLAG_EN to add out_flush, set when the operand shifts entirely into sticky.
module man_align_pipe #(
   parameter int MAN_W   = 24,
   parameter int SHAMT_W = 5,
   parameter int LAT     = 2,
   parameter int TAG_W   = 9
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [MAN_W-1:0]   in_man,
   input  logic [SHAMT_W-1:0] in_shamt,
   input  logic [TAG_W-1:0]   in_tag,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [MAN_W+2:0]   out_res,
   output logic [TAG_W-1:0]   out_tag
`ifdef MAN_ALIGN_FLUSH_FLAG_EN
   ,
   output logic               out_flush
`endif
);
   localparam int EXT_W = MAN_W + 2;
   localparam int GRP   = (SHAMT_W + LAT - 1) / LAT;

   // Applies up to cnt binary shift steps; sh bit k shifts by 2^(base+k) and folds dropped bits into sticky.
   function automatic logic [EXT_W:0] shift_group(input logic [EXT_W-1:0] d, input logic s,
                                                  input logic [SHAMT_W-1:0] sh, input int base,
                                                  input int cnt);
      logic [EXT_W-1:0] dd;
      logic             ss;
      int               amt;
      dd = d;
      ss = s;
      for (int k = 0; k < SHAMT_W; k++) begin
         if (k < cnt && sh[k]) begin
            amt = 1 << (base + k);
            ss  = ss | (|(dd & ~({EXT_W{1'b1}} << amt)));
            dd  = dd >> amt;
         end
      end
      return {dd, ss};
   endfunction

   logic [LAT:0]   adv;
   logic [LAT-1:0] vld_vec;

   always_comb begin
      adv      = '0;
      adv[LAT] = out_ready;
      for (int i = LAT - 1; i >= 0; i--) begin
         adv[i] = !vld_vec[i] || adv[i+1];
      end
   end

   assign in_ready = adv[0];

   for (genvar g = 0; g < LAT; g++) begin : g_slot
      // The last group takes every remaining shamt bit, so nothing is left to carry past it.
      localparam int CNT = (g == LAT - 1) ? SHAMT_W : GRP;

      logic               src_vld;
      logic [EXT_W-1:0]   src_d;
      logic               src_s;
      logic [SHAMT_W-1:0] src_sh;
      logic [TAG_W-1:0]   src_tag;
      logic [EXT_W:0]     shifted;
      logic               vld_q;
      logic [EXT_W-1:0]   d_q;
      logic               s_q;
      logic [TAG_W-1:0]   tag_q;
`ifdef MAN_ALIGN_FLUSH_FLAG_EN
      logic               src_fl;
      logic               fl_q;
`endif

      if (g == 0) begin : g_src
         assign src_vld = in_valid;
         assign src_d   = {in_man, 2'b00};
         assign src_s   = 1'b0;
         assign src_sh  = in_shamt;
         assign src_tag = in_tag;
`ifdef MAN_ALIGN_FLUSH_FLAG_EN
         assign src_fl  = int'(in_shamt) >= EXT_W;
`endif
      end else begin : g_src
         assign src_vld = g_slot[g-1].vld_q;
         assign src_d   = g_slot[g-1].d_q;
         assign src_s   = g_slot[g-1].s_q;
         assign src_sh  = g_slot[g-1].g_sh.sh_q;
         assign src_tag = g_slot[g-1].tag_q;
`ifdef MAN_ALIGN_FLUSH_FLAG_EN
         assign src_fl  = g_slot[g-1].fl_q;
`endif
      end

      assign shifted    = shift_group(src_d, src_s, src_sh, g * GRP, CNT);
      assign vld_vec[g] = vld_q;

      // Stage boundary: slot g register
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            vld_q <= 1'b0;
            d_q   <= '0;
            s_q   <= 1'b0;
            tag_q <= '0;
`ifdef MAN_ALIGN_FLUSH_FLAG_EN
            fl_q  <= 1'b0;
`endif
         end else if (adv[g]) begin
            vld_q <= src_vld;
            if (src_vld) begin
               d_q   <= shifted[EXT_W:1];
               s_q   <= shifted[0];
               tag_q <= src_tag;
`ifdef MAN_ALIGN_FLUSH_FLAG_EN
               fl_q  <= src_fl;
`endif
            end
         end
      end

      if (g < LAT - 1) begin : g_sh
         logic [SHAMT_W-1:0] sh_q;
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               sh_q <= '0;
            end else if (adv[g] && src_vld) begin
               sh_q <= src_sh >> GRP;
            end
         end
      end
   end

   assign out_valid = g_slot[LAT-1].vld_q;
   assign out_res   = {g_slot[LAT-1].d_q, g_slot[LAT-1].s_q};
   assign out_tag   = g_slot[LAT-1].tag_q;
`ifdef MAN_ALIGN_FLUSH_FLAG_EN
   assign out_flush = g_slot[LAT-1].fl_q;
`endif

endmodule

// File: tb/tb_man_align_pipe.sv
// Bench for man_align_pipe: default build plus LAT=1 and LAT=5 sweeps at MAN_W=53, scoreboard checked.
module tb_man_align_pipe;
   localparam int MW  = 24;
   localparam int SW  = 5;
   localparam int TW  = 9;
   localparam int MW2 = 53;
   localparam int SW2 = 6;

   logic clk = 1'b0;
   logic rst_n;
   int   cyc    = 0;
   int   total  = 0;
   int   passed = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   logic          a_iv, a_ir, a_ov, a_or;
   logic [MW-1:0] a_man;
   logic [SW-1:0] a_sh;
   logic [TW-1:0] a_tag, a_otag;
   logic [MW+2:0] a_res;

   logic           b_iv, b_ir, b_ov, b_or, c_iv, c_ir, c_ov, c_or;
   logic [MW2-1:0] b_man, c_man;
   logic [SW2-1:0] b_sh, c_sh;
   logic [TW-1:0]  b_tag, b_otag, c_tag, c_otag;
   logic [MW2+2:0] b_res, c_res;

   logic [63:0]   a_exp_q[$];
   logic [TW-1:0] a_tag_q[$];
   int            a_cyc_q[$];
   logic [63:0]   b_exp_q[$], c_exp_q[$];
   logic [TW-1:0] b_tag_q[$], c_tag_q[$];
   int            b_cyc_q[$], c_cyc_q[$];
`ifdef MAN_ALIGN_FLUSH_FLAG_EN
   logic a_fl, b_fl, c_fl;
   logic a_fl_q[$], b_fl_q[$], c_fl_q[$];
`endif

   man_align_pipe #(.MAN_W(MW), .SHAMT_W(SW), .LAT(2), .TAG_W(TW)) u_dut (
      .clk(clk), .rst_n(rst_n), .in_valid(a_iv), .in_ready(a_ir), .in_man(a_man),
      .in_shamt(a_sh), .in_tag(a_tag), .out_valid(a_ov), .out_ready(a_or),
      .out_res(a_res), .out_tag(a_otag)
`ifdef MAN_ALIGN_FLUSH_FLAG_EN
      , .out_flush(a_fl)
`endif
   );

   man_align_pipe #(.MAN_W(MW2), .SHAMT_W(SW2), .LAT(1), .TAG_W(TW)) u_lat1 (
      .clk(clk), .rst_n(rst_n), .in_valid(b_iv), .in_ready(b_ir), .in_man(b_man),
      .in_shamt(b_sh), .in_tag(b_tag), .out_valid(b_ov), .out_ready(b_or),
      .out_res(b_res), .out_tag(b_otag)
`ifdef MAN_ALIGN_FLUSH_FLAG_EN
      , .out_flush(b_fl)
`endif
   );

   man_align_pipe #(.MAN_W(MW2), .SHAMT_W(SW2), .LAT(5), .TAG_W(TW)) u_lat5 (
      .clk(clk), .rst_n(rst_n), .in_valid(c_iv), .in_ready(c_ir), .in_man(c_man),
      .in_shamt(c_sh), .in_tag(c_tag), .out_valid(c_ov), .out_ready(c_or),
      .out_res(c_res), .out_tag(c_otag)
`ifdef MAN_ALIGN_FLUSH_FLAG_EN
      , .out_flush(c_fl)
`endif
   );

   // Reference aligner: {ext >> sh, sticky}, saturating once sh reaches mw+2.
   function automatic logic [63:0] model(input logic [63:0] man, input int mw, input int sh);
      logic [63:0] ext, mask;
      ext = man << 2;
      if (sh >= mw + 2) return {63'd0, |man};
      mask = (64'd1 << sh) - 64'd1;
      return ((ext >> sh) << 1) | {63'd0, |(ext & mask)};
   endfunction

   task automatic test_reset();
      rst_n = 1'b0;
      a_iv = 1'b0; a_or = 1'b1; a_man = '0; a_sh = '0; a_tag = '0;
      b_iv = 1'b0; b_or = 1'b1; b_man = '0; b_sh = '0; b_tag = '0;
      c_iv = 1'b0; c_or = 1'b1; c_man = '0; c_sh = '0; c_tag = '0;
      repeat (2) @(negedge clk);
      total++; if (a_ov !== 1'b0) $display("FAIL reset_out_valid got=%b want=0", a_ov); else passed++;
      total++; if (a_res !== '0) $display("FAIL reset_out_res got=%h want=0", a_res); else passed++;
      total++; if (a_otag !== '0) $display("FAIL reset_out_tag got=%h want=0", a_otag); else passed++;
      total++; if (a_ir !== 1'b1) $display("FAIL reset_in_ready got=%b want=1", a_ir); else passed++;
      total++; if (b_ov !== 1'b0 || c_ov !== 1'b0) $display("FAIL reset_sweep_valid got=%b%b want=00", b_ov, c_ov); else passed++;
`ifdef MAN_ALIGN_FLUSH_FLAG_EN
      total++; if (a_fl !== 1'b0) $display("FAIL reset_out_flush got=%b want=0", a_fl); else passed++;
`endif
      rst_n = 1'b1;
   endtask

   task automatic test_directed();
      logic [MW-1:0] vm [8];
      logic [SW-1:0] vs [8];
      logic [MW+2:0] ve [8];
      logic [63:0]   er;
      logic [TW-1:0] et;
      int            ec, i;
      vm = '{24'b110110011001100110011010, 24'b111101001100001110101101, 24'h000001, 24'h000000,
             24'hABCDEF, 24'h800000, 24'h800001, 24'hFFFFFF};
      vs = '{5'd5, 5'd4, 5'd31, 5'd31, 5'd0, 5'd25, 5'd26, 5'd1};
      ve = '{27'b000001101100110011001100111, 27'b000011110100110000111010111, 27'd1, 27'd0,
             {24'hABCDEF, 3'b000}, 27'd2, 27'd1, 27'h3FFFFFC};
      i = 0;
      for (int n = 0; n < 40 && (i < 8 || a_exp_q.size() != 0); n++) begin
         @(negedge clk);
         a_or = 1'b1;
         a_iv = (i < 8);
         if (i < 8) begin
            a_man = vm[i]; a_sh = vs[i]; a_tag = (i == 1) ? 9'h1A5 : TW'(i * 37 + 3);
         end
         #1;
         if (a_ov && a_or) begin
            total++;
            if (a_exp_q.size() == 0) $display("FAIL dir_extra got=%h want=none", a_res);
            else begin
               er = a_exp_q.pop_front(); et = a_tag_q.pop_front(); ec = a_cyc_q.pop_front();
               if (a_res !== er[MW+2:0]) $display("FAIL dir_res got=%b want=%b", a_res, er[MW+2:0]); else passed++;
               total++; if (a_otag !== et) $display("FAIL dir_tag got=%h want=%h", a_otag, et); else passed++;
               total++; if (cyc - ec != 2) $display("FAIL dir_latency got=%0d want=2", cyc - ec); else passed++;
`ifdef MAN_ALIGN_FLUSH_FLAG_EN
               total++; if (a_fl !== a_fl_q.pop_front()) $display("FAIL dir_flush got=%b", a_fl); else passed++;
`endif
            end
         end
         if (a_iv && a_ir) begin
            a_exp_q.push_back(64'(ve[i])); a_tag_q.push_back(a_tag); a_cyc_q.push_back(cyc);
`ifdef MAN_ALIGN_FLUSH_FLAG_EN
            a_fl_q.push_back(int'(a_sh) >= MW + 2);
`endif
            i++;
         end
      end
      total++; if (i != 8 || a_exp_q.size() != 0) $display("FAIL dir_drain got=%0d/%0d want=8/0", i, a_exp_q.size()); else passed++;
   endtask

   task automatic test_backpressure();
      logic [MW-1:0] bm [6];
      logic [SW-1:0] bs [6];
      logic [MW+2:0] held;
      logic          have_held;
      logic [63:0]   er;
      logic [TW-1:0] et;
      int            i;
      for (int k = 0; k < 6; k++) begin
         bm[k] = MW'($urandom); bs[k] = SW'($urandom_range(0, 31));
      end
      i = 0; have_held = 1'b0; held = '0;
      for (int n = 0; n < 8; n++) begin
         @(negedge clk);
         a_or = 1'b0;
         a_iv = (i < 6);
         if (i < 6) begin a_man = bm[i]; a_sh = bs[i]; a_tag = TW'(100 + i); end
         #1;
         if (a_ov) begin
            if (!have_held) begin held = a_res; have_held = 1'b1; end
            else begin
               total++; if (a_res !== held) $display("FAIL bp_hold got=%h want=%h", a_res, held); else passed++;
            end
         end
         if (a_iv && a_ir) begin
            a_exp_q.push_back(model(64'(a_man), MW, int'(a_sh))); a_tag_q.push_back(a_tag); a_cyc_q.push_back(cyc);
`ifdef MAN_ALIGN_FLUSH_FLAG_EN
            a_fl_q.push_back(int'(a_sh) >= MW + 2);
`endif
            i++;
         end
      end
      total++; if (i != 2) $display("FAIL bp_accepts got=%0d want=2", i); else passed++;
      total++; if (a_ir !== 1'b0) $display("FAIL bp_in_ready got=%b want=0", a_ir); else passed++;
      for (int n = 0; n < 60 && (i < 6 || a_exp_q.size() != 0); n++) begin
         @(negedge clk);
         a_or = 1'b1;
         a_iv = (i < 6);
         if (i < 6) begin a_man = bm[i]; a_sh = bs[i]; a_tag = TW'(100 + i); end
         #1;
         if (a_ov && a_or) begin
            total++;
            if (a_exp_q.size() == 0) $display("FAIL bp_extra got=%h want=none", a_res);
            else begin
               er = a_exp_q.pop_front(); et = a_tag_q.pop_front(); void'(a_cyc_q.pop_front());
               if (a_res !== er[MW+2:0]) $display("FAIL bp_res got=%h want=%h", a_res, er[MW+2:0]); else passed++;
               total++; if (a_otag !== et) $display("FAIL bp_order got=%h want=%h", a_otag, et); else passed++;
`ifdef MAN_ALIGN_FLUSH_FLAG_EN
               total++; if (a_fl !== a_fl_q.pop_front()) $display("FAIL bp_flush got=%b", a_fl); else passed++;
`endif
            end
         end
         if (a_iv && a_ir) begin
            a_exp_q.push_back(model(64'(a_man), MW, int'(a_sh))); a_tag_q.push_back(a_tag); a_cyc_q.push_back(cyc);
`ifdef MAN_ALIGN_FLUSH_FLAG_EN
            a_fl_q.push_back(int'(a_sh) >= MW + 2);
`endif
            i++;
         end
      end
      total++; if (i != 6 || a_exp_q.size() != 0) $display("FAIL bp_drain got=%0d/%0d want=6/0", i, a_exp_q.size()); else passed++;
   endtask

   task automatic test_back_to_back();
      logic [63:0]   er;
      logic [TW-1:0] et;
      int            i;
      i = 0;
      for (int n = 0; n < 400 && (i < 40 || a_exp_q.size() != 0); n++) begin
         @(negedge clk);
         a_or = ($urandom_range(0, 3) != 0);
         if (!(a_iv && !a_ir) || i >= 40) begin
            a_iv = (i < 40) && ($urandom_range(0, 3) != 0);
            a_man = MW'($urandom); a_sh = SW'($urandom_range(0, 31)); a_tag = TW'($urandom);
         end
         #1;
         if (a_ov && a_or) begin
            total++;
            if (a_exp_q.size() == 0) $display("FAIL b2b_extra got=%h want=none", a_res);
            else begin
               er = a_exp_q.pop_front(); et = a_tag_q.pop_front(); void'(a_cyc_q.pop_front());
               if (a_res !== er[MW+2:0]) $display("FAIL b2b_res got=%h want=%h", a_res, er[MW+2:0]); else passed++;
               total++; if (a_otag !== et) $display("FAIL b2b_tag got=%h want=%h", a_otag, et); else passed++;
`ifdef MAN_ALIGN_FLUSH_FLAG_EN
               total++; if (a_fl !== a_fl_q.pop_front()) $display("FAIL b2b_flush got=%b", a_fl); else passed++;
`endif
            end
         end
         if (a_iv && a_ir) begin
            a_exp_q.push_back(model(64'(a_man), MW, int'(a_sh))); a_tag_q.push_back(a_tag); a_cyc_q.push_back(cyc);
`ifdef MAN_ALIGN_FLUSH_FLAG_EN
            a_fl_q.push_back(int'(a_sh) >= MW + 2);
`endif
            i++;
         end
      end
      total++; if (i != 40 || a_exp_q.size() != 0) $display("FAIL b2b_drain got=%0d/%0d want=40/0", i, a_exp_q.size()); else passed++;
   endtask

   task automatic test_reset_midflight();
      logic [63:0]   er;
      logic [TW-1:0] et;
      int            i, ec, outs;
      i = 0;
      for (int n = 0; n < 10 && i < 2; n++) begin
         @(negedge clk);
         a_or = 1'b0; a_iv = 1'b1; a_man = MW'($urandom); a_sh = SW'($urandom_range(0, 31)); a_tag = TW'(200 + i);
         #1;
         if (a_iv && a_ir) i++;
      end
      @(negedge clk);
      a_iv = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      total++; if (a_ov !== 1'b0) $display("FAIL rst_mid_out_valid got=%b want=0", a_ov); else passed++;
      total++; if (a_ir !== 1'b1) $display("FAIL rst_mid_in_ready got=%b want=1", a_ir); else passed++;
      @(negedge clk);
      rst_n = 1'b1;
      i = 0; outs = 0;
      for (int n = 0; n < 10; n++) begin
         @(negedge clk);
         a_or = 1'b1; a_iv = (i < 1);
         a_man = 24'h9A3C05; a_sh = 5'd7; a_tag = 9'h0F0;
         #1;
         if (a_ov && a_or) begin
            total++; outs++;
            if (a_exp_q.size() == 0) $display("FAIL rst_mid_extra got=%h want=none", a_res);
            else begin
               er = a_exp_q.pop_front(); et = a_tag_q.pop_front(); ec = a_cyc_q.pop_front();
               if (a_res !== er[MW+2:0]) $display("FAIL rst_mid_res got=%h want=%h", a_res, er[MW+2:0]); else passed++;
               total++; if (a_otag !== et) $display("FAIL rst_mid_tag got=%h want=%h", a_otag, et); else passed++;
               total++; if (cyc - ec != 2) $display("FAIL rst_mid_latency got=%0d want=2", cyc - ec); else passed++;
`ifdef MAN_ALIGN_FLUSH_FLAG_EN
               total++; if (a_fl !== a_fl_q.pop_front()) $display("FAIL rst_mid_flush got=%b", a_fl); else passed++;
`endif
            end
         end
         if (a_iv && a_ir) begin
            a_exp_q.push_back(model(64'(a_man), MW, int'(a_sh))); a_tag_q.push_back(a_tag); a_cyc_q.push_back(cyc);
`ifdef MAN_ALIGN_FLUSH_FLAG_EN
            a_fl_q.push_back(int'(a_sh) >= MW + 2);
`endif
            i++;
         end
      end
      total++; if (outs != 1 || a_exp_q.size() != 0) $display("FAIL rst_mid_count got=%0d want=1", outs); else passed++;
   endtask

   task automatic test_sweep();
      logic [MW2-1:0] m;
      logic [SW2-1:0] s;
      logic [63:0]    er;
      logic [TW-1:0]  et;
      int             i, ec;
      logic           fb, fc;
      i = 0; m = '0; s = '0;
      for (int n = 0; n < 200 && (i < 64 || b_exp_q.size() != 0 || c_exp_q.size() != 0); n++) begin
         @(negedge clk);
         b_or = 1'b1; c_or = 1'b1;
         b_iv = (i < 64); c_iv = (i < 64);
         if (i == 0) s = 6'd54; else if (i == 1) s = 6'd55; else if (i == 2) s = 6'd0; else s = SW2'($urandom_range(0, 63));
         m = (i % 16 == 5) ? '0 : MW2'({$urandom(), $urandom()});
         b_man = m; c_man = m; b_sh = s; c_sh = s; b_tag = TW'(i); c_tag = TW'(i);
         #1;
         if (b_ov) begin
            total++;
            if (b_exp_q.size() == 0) $display("FAIL lat1_extra got=%h want=none", b_res);
            else begin
               er = b_exp_q.pop_front(); et = b_tag_q.pop_front(); ec = b_cyc_q.pop_front();
               if (b_res !== er[MW2+2:0]) $display("FAIL lat1_res got=%h want=%h", b_res, er[MW2+2:0]); else passed++;
               total++; if (b_otag !== et) $display("FAIL lat1_tag got=%h want=%h", b_otag, et); else passed++;
               total++; if (cyc - ec != 1) $display("FAIL lat1_latency got=%0d want=1", cyc - ec); else passed++;
`ifdef MAN_ALIGN_FLUSH_FLAG_EN
               total++; if (b_fl !== b_fl_q.pop_front()) $display("FAIL lat1_flush got=%b", b_fl); else passed++;
`endif
            end
         end
         if (c_ov) begin
            total++;
            if (c_exp_q.size() == 0) $display("FAIL lat5_extra got=%h want=none", c_res);
            else begin
               er = c_exp_q.pop_front(); et = c_tag_q.pop_front(); ec = c_cyc_q.pop_front();
               if (c_res !== er[MW2+2:0]) $display("FAIL lat5_res got=%h want=%h", c_res, er[MW2+2:0]); else passed++;
               total++; if (c_otag !== et) $display("FAIL lat5_tag got=%h want=%h", c_otag, et); else passed++;
               total++; if (cyc - ec != 5) $display("FAIL lat5_latency got=%0d want=5", cyc - ec); else passed++;
`ifdef MAN_ALIGN_FLUSH_FLAG_EN
               total++; if (c_fl !== c_fl_q.pop_front()) $display("FAIL lat5_flush got=%b", c_fl); else passed++;
`endif
            end
         end
         fb = b_iv && b_ir;
         fc = c_iv && c_ir;
         if (fb) begin
            b_exp_q.push_back(model(64'(m), MW2, int'(s))); b_tag_q.push_back(b_tag); b_cyc_q.push_back(cyc);
`ifdef MAN_ALIGN_FLUSH_FLAG_EN
            b_fl_q.push_back(int'(s) >= MW2 + 2);
`endif
         end
         if (fc) begin
            c_exp_q.push_back(model(64'(m), MW2, int'(s))); c_tag_q.push_back(c_tag); c_cyc_q.push_back(cyc);
`ifdef MAN_ALIGN_FLUSH_FLAG_EN
            c_fl_q.push_back(int'(s) >= MW2 + 2);
`endif
         end
         if (i < 64) begin
            total++;
            if (!(fb && fc)) $display("FAIL sweep_in_ready got=%b%b want=11", b_ir, c_ir); else passed++;
            i++;
         end
      end
      b_iv = 1'b0; c_iv = 1'b0;
      total++;
      if (b_exp_q.size() != 0 || c_exp_q.size() != 0)
         $display("FAIL sweep_drain got=%0d/%0d want=0/0", b_exp_q.size(), c_exp_q.size());
      else passed++;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_directed();
      test_backpressure();
      test_back_to_back();
      test_reset_midflight();
      test_sweep();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/man_align_pipe.md
Name: man_align_pipe

Overview:
- Pipelined, parametrised mantissa alignment shifter for the fp adder's exponent-difference path.
- Right-shifts the smaller operand's mantissa by shamt and appends guard, round and sticky bits.
- Uses a valid/ready handshake with backpressure and carries a sideband tag (sign/exponent) alongside the data.
- Replaces the single-cycle combinational aligner. Generalised in mantissa width, shift width, latency and tag width, and handles saturating shifts.

Parameters:
- MAN_W, 24, mantissa width including hidden bit.
- SHAMT_W, 5, shift-amount width.
- LAT, 2, register stages, 1..SHAMT_W; equals the latency in cycles.
- TAG_W, 9, sideband width passed through unchanged.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  aligner can accept a beat.
- in_man  in  MAN_W  mantissa to align.
- in_shamt  in  SHAMT_W  right-shift amount.
- in_tag  in  TAG_W  sideband data.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts.
- out_res  out  MAN_W+3  {shifted mantissa, G, R, S}.
- out_tag  out  TAG_W  tag aligned with out_res.

Behaviour:
- Reset is asynchronous and active-low; one clock domain.
- Reset values: every stage valid=0, out_valid=0, out_res=0, out_tag=0, in_ready=1.
- Arithmetic:
  - ext = {in_man, 2'b00} (MAN_W+2 bits); kept = ext >> shamt.
  - S = OR of all bits of ext shifted below bit 0.
  - out_res = {kept, S}.
- Saturation: if shamt >= MAN_W+2, kept = 0 and S = |in_man. This also covers shamt values above MAN_W+2.
- shamt=0: out_res = {in_man, 3'b000}.
- Staging:
  - The shift is decomposed into SHAMT_W binary stages (shift by 2^k).
  - Each stage ORs the bits it drops into a running sticky bit carried with the data.
  - Stages are grouped into LAT registered groups of ceil(SHAMT_W/LAT) bit-stages each; the last group may hold fewer.
  - Each register slot holds valid, partial data, sticky, remaining shamt bits and tag.
- Latency: LAT cycles from the in_valid && in_ready cycle to out_valid, when there is no backpressure.
- Throughput: one beat per cycle when out_ready=1.
- Handshake, per slot i:
  - adv_i = !valid_i || adv_{i+1}, with adv_LAT = out_ready.
  - in_ready = adv_0.
  - A slot loads on adv_i and becomes valid with its upstream valid.
  - Bubbles collapse: an empty slot accepts even while downstream is stalled.
- Stability while stalled: out_valid && !out_ready holds out_res and out_tag stable until accepted.
- in_valid && !in_ready: the beat is not taken, and the source must hold it.
- Simultaneous accept-out and accept-in in one cycle: no beat is lost or duplicated, and order is preserved.
- Full pipeline with out_ready=0: in_ready=0 combinationally.
- Reset mid-operation drops all in-flight beats; out_valid=0 on the same edge rather than waiting for a clock.

Optional Feature:
- Macro: MAN_ALIGN_FLUSH_FLAG_EN.
- With the macro defined:
  - Adds output out_flush (1 bit), registered with out_res. Reset value 0.
  - out_flush = 1 when shamt >= MAN_W+2, i.e. the operand is fully flushed into sticky.
- Without the macro: port and logic are absent; the datapath is unchanged.

Test Plan:
- Defaults, LAT=2: man=24'b110110011001100110011010, shamt=5 -> out_res=27'b000001101100110011001100111 two cycles after accept.
- man=24'b111101001100001110101101, shamt=4 -> out_res=27'b000011110100110000111010111; tag 9'h1A5 returned unchanged.
- Saturation: man=24'h000001, shamt=31 -> out_res=27'b0...01.
  - With MAN_ALIGN_FLUSH_FLAG_EN: out_flush=1.
  - man=0, shamt=31 -> out_res=0.
- Backpressure:
  - Stream of 6 beats with out_ready=0 -> after 2 accepts in_ready=0 and out_res stays constant.
  - Release out_ready -> all 6 beats emerge in order with no loss.
- Reset: assert rst_n=0 between edges with 2 beats in flight -> out_valid=0 immediately and in_ready=1. After release, the next beat alone emerges LAT cycles later.
- Parameter sweep: LAT=1 and LAT=5, MAN_W=53, SHAMT_W=6, random man/shamt at full throughput -> every output matches the arithmetic model, latency equals LAT.
